// File: rtl/led_display_row_driver.sv
// HUB75 row driver: takes one colour row per handshake, shifts it MSB-first on six
// serial lines with a generated bit clock, then blanks, sets the address and latches.
package led_display_pkg;
  localparam int GL_NUM_COL_PIXELS = 64;

  typedef struct packed {
    logic [GL_NUM_COL_PIXELS-1:0] red;
    logic [GL_NUM_COL_PIXELS-1:0] green;
    logic [GL_NUM_COL_PIXELS-1:0] blue;
  } rgb_field_t;

  typedef struct packed {
    rgb_field_t top;
    rgb_field_t bot;
  } rgb_row_t;

  localparam int GL_RGB_ROW_W = $bits(rgb_row_t);
endpackage

// One serial colour line: picks bit NUM_COL_PIXELS-1-col of its field.
module led_row_lane #(
  parameter int NUM_COL_PIXELS = 64,
  parameter int COL_W          = 6
) (
  input  logic [NUM_COL_PIXELS-1:0] field,
  input  logic [COL_W-1:0]          col,
  input  logic                      en,
  output logic                      bit_out
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COL_PIXELS - 1);

  logic [COL_W-1:0] idx;

  always_comb begin
    idx     = COL_LAST - col;
    bit_out = en & field[idx];
  end
endmodule

module led_display_row_driver
  import led_display_pkg::*;
#(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int BCLK_FREQ      = 21_000_000,
  parameter int NUM_COL_PIXELS = GL_NUM_COL_PIXELS,
  parameter int ON_CYCLES      = 1000
) (
  input  logic       clk_in,
  input  logic       n_reset_in,
  input  rgb_row_t   row_in,
  input  logic       row_valid_in,
  output logic       row_ready_out,
  input  logic [3:0] row_address_in,
  output logic       r0_out,
  output logic       g0_out,
  output logic       b0_out,
  output logic       r1_out,
  output logic       g1_out,
  output logic       b1_out,
  output logic       bclk_out,
  output logic       latch_out,
  output logic       n_oe_out,
  output logic [3:0] addr_out
);
  localparam int BCLK_DIV_RAW = (SYS_CLK_FREQ + BCLK_FREQ - 1) / BCLK_FREQ;
  localparam int BCLK_DIV     = (BCLK_DIV_RAW < 2) ? 2 : BCLK_DIV_RAW;
  localparam int BCLK_HI      = BCLK_DIV / 2;
  localparam int BCLK_LO      = BCLK_DIV - BCLK_HI;
  localparam int BIT_W        = $clog2(BCLK_DIV);
  localparam int COL_W        = (NUM_COL_PIXELS < 2) ? 1 : $clog2(NUM_COL_PIXELS);
  localparam int ON_W         = (ON_CYCLES < 1) ? 1 : $clog2(ON_CYCLES + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_RISE = BIT_W'(BCLK_LO);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COL_PIXELS - 1);
  localparam logic [ON_W-1:0]  ON_MAX   = ON_W'(ON_CYCLES);

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT_ON, BLANK, LATCH} state_t;

  state_t           state, state_n;
  logic [BIT_W-1:0] bit_cnt, bit_n;
  logic [COL_W-1:0] col_cnt, col_n;
  logic [ON_W-1:0]  on_cnt, on_n;
  rgb_row_t         row_q, row_src;
  logic [3:0]       addr_q;
  logic             accept, on_done, bit_last;

  logic [5:0][NUM_COL_PIXELS-1:0] lane_data;
  logic [5:0]                     lane_bit;
  logic                           shift_n, ready_n, bclk_n, latch_n, noe_n;
  logic [3:0]                     addr_n;

  assign accept   = (state == IDLE) && row_valid_in;
  assign on_done  = (on_cnt >= ON_MAX);
  assign bit_last = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state   <= IDLE;
      bit_cnt <= '0;
      col_cnt <= '0;
      on_cnt  <= ON_MAX;
      row_q   <= '0;
      addr_q  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      col_cnt <= col_n;
      on_cnt  <= on_n;
      if (accept) begin
        row_q  <= row_in;
        addr_q <= row_address_in;
      end
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    col_n   = col_cnt;
    case (state)
      IDLE:
        if (row_valid_in) begin
          state_n = SHIFT;
          bit_n   = '0;
          col_n   = '0;
        end
      SHIFT:
        if (bit_last) begin
          bit_n = '0;
          if (col_cnt == COL_LAST) begin
            col_n   = '0;
            state_n = on_done ? BLANK : WAIT_ON;
          end else begin
            col_n = col_cnt + 1'b1;
          end
        end else begin
          bit_n = bit_cnt + 1'b1;
        end
      WAIT_ON:
        if (on_done) begin
          state_n = BLANK;
          bit_n   = '0;
        end
      BLANK:
        if (bit_last) begin
          state_n = LATCH;
          bit_n   = '0;
        end else begin
          bit_n = bit_cnt + 1'b1;
        end
      LATCH:
        if (bit_last) begin
          state_n = IDLE;
          bit_n   = '0;
        end else begin
          bit_n = bit_cnt + 1'b1;
        end
      default: state_n = IDLE;
    endcase

    // On-time restarts as the panel is re-enabled and saturates once elapsed.
    if (state == LATCH && bit_last) on_n = '0;
    else if (!on_done)              on_n = on_cnt + 1'b1;
    else                            on_n = on_cnt;
  end

  // Outputs are registered from the next state, so column 0 is on the pins at the accept edge.
  assign row_src   = accept ? row_in : row_q;
  assign lane_data = {row_src.top.red, row_src.top.green, row_src.top.blue,
                      row_src.bot.red, row_src.bot.green, row_src.bot.blue};
  assign shift_n   = (state_n == SHIFT);

  generate
    for (genvar l = 0; l < 6; l++) begin : g_lane
      led_row_lane #(.NUM_COL_PIXELS(NUM_COL_PIXELS), .COL_W(COL_W)) u_lane (
        .field  (lane_data[l]),
        .col    (col_n),
        .en     (shift_n),
        .bit_out(lane_bit[l])
      );
    end
  endgenerate

  always_comb begin
    ready_n = (state_n == IDLE);
    bclk_n  = shift_n && (bit_n >= BIT_RISE);
    latch_n = (state_n == LATCH);
    noe_n   = n_oe_out;
    if (state_n == BLANK || state_n == LATCH) noe_n = 1'b1;
    else if (state == LATCH)                  noe_n = 1'b0;
    addr_n  = (state_n == BLANK && state != BLANK) ? addr_q : addr_out;
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      row_ready_out <= 1'b1;
      {r0_out, g0_out, b0_out, r1_out, g1_out, b1_out} <= '0;
      bclk_out      <= 1'b0;
      latch_out     <= 1'b0;
      n_oe_out      <= 1'b1;
      addr_out      <= '0;
    end else begin
      row_ready_out <= ready_n;
      {r0_out, g0_out, b0_out, r1_out, g1_out, b1_out} <= lane_bit;
      bclk_out      <= bclk_n;
      latch_out     <= latch_n;
      n_oe_out      <= noe_n;
      addr_out      <= addr_n;
    end
  end
endmodule
